// File: rtl/exc_ctrl.sv
// exc_ctrl: commits WB-stage exceptions, interrupts and ERTN to the CSR file,
// then flushes the pipeline and hands a redirect target to fetch.
module exc_ctrl #(
  parameter int         FLUSH_CYCLES = 2,
  parameter logic [5:0] ECODE_INT    = 6'h00
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ex_valid,
  input  logic [5:0]  ex_ecode,
  input  logic [8:0]  ex_esubcode,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_vaddr,
  input  logic        wb_inst_valid,
  input  logic        ertn_req,
  input  logic        has_int,
  input  logic [31:0] eentry,
  input  logic [31:0] era,
  input  logic        redirect_ready,
  output logic        wb_cancel,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy,
  output logic [15:0] exc_cnt
);
  typedef enum logic [1:0] {IDLE, FLUSH, REDIRECT} state_t;
  state_t state, state_nx;
  logic [3:0] fcnt;
  logic idle, irq, take_ex, take_int, take_ertn, take;
  always_comb begin
    idle           = state == IDLE;
    irq            = has_int && wb_inst_valid;
    take_ex        = idle && ex_valid;
    take_int       = idle && !ex_valid && irq;
    take_ertn      = idle && !ex_valid && !irq && ertn_req && wb_inst_valid;
    take           = take_ex || take_int || take_ertn;
    wb_cancel      = take_ex || take_int;
    flush          = state == FLUSH;
    redirect_valid = state == REDIRECT;
    busy           = !idle;
    state_nx = idle ? (take ? FLUSH : IDLE) :
               flush ? (fcnt == 4'd0 ? REDIRECT : FLUSH) :
               redirect_valid ? (redirect_ready ? IDLE : REDIRECT) : IDLE;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wb_ex       <= 1'b0;
      ertn_flush  <= 1'b0;
      wb_ecode    <= '0;
      wb_esubcode <= '0;
      wb_pc       <= '0;
      wb_vaddr    <= '0;
      redirect_pc <= '0;
      exc_cnt     <= '0;
      fcnt        <= '0;
    end else begin
      wb_ex      <= take_ex || take_int;
      ertn_flush <= take_ertn;
      if (take_ex || take_int) begin
        wb_ecode    <= take_ex ? ex_ecode : ECODE_INT;
        wb_esubcode <= take_ex ? ex_esubcode : 9'd0;
        wb_pc       <= ex_pc;
        wb_vaddr    <= take_ex ? ex_vaddr : 32'd0;
        exc_cnt     <= exc_cnt == 16'hFFFF ? exc_cnt : exc_cnt + 16'd1;
      end
      if (take) begin
        redirect_pc <= take_ertn ? era : eentry;
        fcnt        <= 4'(FLUSH_CYCLES - 1);
      end else if (flush && fcnt != 4'd0) fcnt <= fcnt - 4'd1;
    end
  end
endmodule
